run_sequencer: RTL

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - CPU launch/run/halt sequencer with delayed interrupt injection
module run_sequencer #(
    parameter int RST_HOLD    = 4,
    parameter int START_WIDTH = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 32,
    parameter int NUM_IRQ     = 2,
    parameter int IRQ_DELAY   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               cpu_halt,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_ack,
    output logic               cpu_rst_n,
    output logic               cpu_start,
    output logic [NUM_IRQ-1:0] interrupt,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int PH_MAX = (RST_HOLD > START_WIDTH) ? RST_HOLD : START_WIDTH;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int DLY_W  = (IRQ_DELAY > 1) ? $clog2(IRQ_DELAY + 1) : 1;

    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(RST_HOLD - 1);
    localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DLY_W-1:0] DLY_INIT   = DLY_W'(IRQ_DELAY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    state_t                          state, state_nx;
    logic [PH_W-1:0]                 ph_cnt, ph_cnt_nx;
    logic [NUM_IRQ-1:0]              armed, armed_nx;
    logic [NUM_IRQ-1:0][DLY_W-1:0]   dly, dly_nx;
    logic [NUM_IRQ-1:0]              interrupt_nx;
    logic                            cpu_rst_n_nx, cpu_start_nx, running_nx;
    logic                            done_nx, timeout_nx;
    logic [CNT_W-1:0]                cycle_count_nx;
    logic                            stay_run;

    // Every output is a flop loaded from the next-state decode, so nothing glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            armed       <= '0;
            dly         <= '0;
            interrupt   <= '0;
            cpu_rst_n   <= 1'b0;
            cpu_start   <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            ph_cnt      <= ph_cnt_nx;
            armed       <= armed_nx;
            dly         <= dly_nx;
            interrupt   <= interrupt_nx;
            cpu_rst_n   <= cpu_rst_n_nx;
            cpu_start   <= cpu_start_nx;
            running     <= running_nx;
            done        <= done_nx;
            timeout     <= timeout_nx;
            cycle_count <= cycle_count_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ph_cnt_nx = ph_cnt;
        case (state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (go) begin
                    state_nx  = S_HOLD;
                    ph_cnt_nx = '0;
                end
            end
            S_HOLD: begin
                if (ph_cnt == HOLD_LAST) begin
                    state_nx  = S_START;
                    ph_cnt_nx = '0;
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            S_START: begin
                if (ph_cnt == START_LAST) begin
                    state_nx  = S_RUN;
                    ph_cnt_nx = '0;
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Halt wins over a timeout landing in the same cycle.
                if (cpu_halt) begin
                    state_nx = S_DONE;
                end else if (cycle_count == CNT_LAST) begin
                    state_nx = S_TOUT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign stay_run = (state == S_RUN) && (state_nx == S_RUN);

    always_comb begin
        cpu_rst_n_nx = !((state_nx == S_IDLE) || (state_nx == S_HOLD));
        cpu_start_nx = (state_nx == S_START);
        running_nx   = (state_nx == S_RUN);
        done_nx      = (state_nx == S_DONE);
        timeout_nx   = (state_nx == S_TOUT);

        cycle_count_nx = cycle_count;
        if (state_nx == S_HOLD) begin
            cycle_count_nx = '0;
        end else if (stay_run) begin
            cycle_count_nx = cycle_count + 1'b1;
        end

        armed_nx     = armed;
        dly_nx       = dly;
        interrupt_nx = interrupt;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!stay_run) begin
                armed_nx[i]     = 1'b0;
                dly_nx[i]       = '0;
                interrupt_nx[i] = 1'b0;
            end else if (interrupt[i]) begin
                if (irq_ack[i]) begin
                    interrupt_nx[i] = 1'b0;
                end
            end else if (armed[i]) begin
                if (dly[i] == '0) begin
                    armed_nx[i]     = 1'b0;
                    interrupt_nx[i] = 1'b1;
                end else begin
                    dly_nx[i] = dly[i] - 1'b1;
                end
            end else if (irq_req[i]) begin
                armed_nx[i] = 1'b1;
                dly_nx[i]   = DLY_INIT;
            end
        end
    end

endmodule
